// File: rtl/irq_controller_multi.sv
// irq_controller_multi: aggregates NUM_IRQ active-low interrupt requests
// behind a 16-byte register window on the 6502 byte bus.
// Registers: ENABLE, MODE, PENDING, VECTOR, CTRL and ACK. The CPU sees one
// registered, active-low irqb_master.
// Define IRQ_EDGE_EN to build edge mode, which adds the MODE registers, the
// edge latches and ACK. Without it, every line is level-sensitive.
module irq_controller_multi #(
    parameter int NUM_IRQ = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         i_data,
    output logic [7:0]         o_data,
    input  logic               cs,
    input  logic               rwb,
    input  logic [3:0]         addr,
    input  logic [NUM_IRQ-1:0] irqb,
    output logic               irqb_master
);

    localparam logic [1:0] BANK_ENABLE = 2'd0;
    localparam logic [1:0] BANK_MODE   = 2'd1;
    localparam logic [1:0] BANK_PEND   = 2'd2;
    localparam logic [1:0] LANE_VECTOR = 2'd0;
    localparam logic [1:0] LANE_CTRL   = 2'd1;
    localparam logic [3:0] ADDR_CTRL   = 4'hD;

    // Per-line write strobe: for a write to one bank, sets the 8 bits of the
    // addressed lane. A lane with no lines behind it gives an all-zero mask,
    // so the write has no effect.
    function automatic logic [NUM_IRQ-1:0] lane_mask(input logic       we,
                                                     input logic [3:0] a,
                                                     input logic [1:0] bank);
        logic [NUM_IRQ-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            m[i] = we && (a[3:2] == bank) && (a[1:0] == 2'(i / 8));
        end
        return m;
    endfunction

    // Byte lane of a per-line vector. Lanes past NUM_IRQ read as zero.
    function automatic logic [7:0] lane_byte(input logic [NUM_IRQ-1:0] v,
                                             input logic [1:0]         lane);
        logic [31:0] pad;
        pad = '0;
        pad[NUM_IRQ-1:0] = v;
        return pad[8*lane +: 8];
    endfunction

    logic               wr;
    logic [NUM_IRQ-1:0] wdata_rep;
    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] enable_sel;
    logic               global_en;
    logic [NUM_IRQ-1:0] req_p0;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] qual;
    logic               vec_valid;
    logic [4:0]         vec_idx;
    logic [7:0]         mode_byte;

    assign wr         = cs & ~rwb;
    assign wdata_rep  = {(NUM_IRQ / 8){i_data}};
    assign enable_sel = lane_mask(wr, addr, BANK_ENABLE);

    // ENABLE register: byte-lane writable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= '0;
        end else begin
            enable_q <= (enable_q & ~enable_sel) | (wdata_rep & enable_sel);
        end
    end

    // CTRL register: global enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            global_en <= 1'b0;
        end else if (wr && (addr == ADDR_CTRL)) begin
            global_en <= i_data[0];
        end
    end

    // Request stage: registered, active-high copy of the request pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_p0 <= '0;
        end else begin
            req_p0 <= ~irqb;
        end
    end

`ifdef IRQ_EDGE_EN
    localparam logic [3:0] ADDR_ACK = 4'hE;

    logic [NUM_IRQ-1:0] mode_q;
    logic [NUM_IRQ-1:0] mode_sel;
    logic [NUM_IRQ-1:0] pend_sel;
    logic [NUM_IRQ-1:0] ack_hit;
    logic [NUM_IRQ-1:0] req_p1;
    logic [NUM_IRQ-1:0] latch_q;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] edge_clr;

    assign mode_sel = lane_mask(wr, addr, BANK_MODE);
    assign pend_sel = lane_mask(wr, addr, BANK_PEND);

    // ACK decode: index compare, so out-of-range indices match no line
    always_comb begin
        ack_hit = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_hit[i] = wr && (addr == ADDR_ACK) && (i_data[4:0] == 5'(i));
        end
    end

    // Latches only move while the line is in edge mode. A latch left behind
    // by a switch to level mode is kept, and is exposed again by a switch back.
    assign edge_set = req_p0 & ~req_p1 & mode_q;
    assign edge_clr = ((pend_sel & wdata_rep) | ack_hit) & mode_q;

    // MODE register: byte-lane writable, 1 = edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= '0;
        end else begin
            mode_q <= (mode_q & ~mode_sel) | (wdata_rep & mode_sel);
        end
    end

    // Request delayed by one clock, used for assertion-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_p1 <= '0;
        end else begin
            req_p1 <= req_p0;
        end
    end

    // Edge latches: if a set and a clear hit the same cycle, the set wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_q <= '0;
        end else begin
            latch_q <= edge_set | (latch_q & ~edge_clr);
        end
    end

    assign pending   = (mode_q & latch_q) | (~mode_q & req_p0);
    assign mode_byte = lane_byte(mode_q, addr[1:0]);
`else
    assign pending   = req_p0;
    assign mode_byte = 8'h00;
`endif

    assign qual      = pending & enable_q;
    assign vec_valid = |qual;

    // Priority encoder: the lowest-numbered qualifying line wins
    always_comb begin
        vec_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (qual[i]) begin
                vec_idx = 5'(i);
            end
        end
    end

    // Read mux: combinational and free of side effects
    always_comb begin
        o_data = 8'h00;
        if (cs) begin
            case (addr[3:2])
                BANK_ENABLE: o_data = lane_byte(enable_q, addr[1:0]);
                BANK_MODE:   o_data = mode_byte;
                BANK_PEND:   o_data = lane_byte(pending, addr[1:0]);
                default: begin
                    case (addr[1:0])
                        LANE_VECTOR: o_data = {vec_valid, 2'b00, vec_idx};
                        LANE_CTRL:   o_data = {7'b0000000, global_en};
                        default:     o_data = 8'h00;
                    endcase
                end
            endcase
        end
    end

    // Aggregated interrupt to the CPU, registered and active-low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqb_master <= 1'b1;
        end else begin
            irqb_master <= ~(global_en & vec_valid);
        end
    end

endmodule

// File: tb/tb_irq_controller_multi.sv
// Directed bench for irq_controller_multi. It runs a 16-line and an 8-line
// instance side by side on a shared CPU bus. The edge-mode sections follow
// whether IRQ_EDGE_EN is defined.
module tb_irq_controller_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  i_data;
    logic        cs;
    logic        rwb;
    logic [3:0]  addr;
    logic [15:0] irqb16;
    logic [7:0]  irqb8;
    logic [7:0]  o_data16;
    logic [7:0]  o_data8;
    logic        master16;
    logic        master8;

    int n_checks = 0;
    int n_errors = 0;

`ifdef IRQ_EDGE_EN
    localparam logic [7:0] MODE_EXP = 8'hFF;
`else
    localparam logic [7:0] MODE_EXP = 8'h00;
`endif

    irq_controller_multi #(.NUM_IRQ(16)) u_dut16 (
        .clk         (clk),
        .reset       (reset),
        .i_data      (i_data),
        .o_data      (o_data16),
        .cs          (cs),
        .rwb         (rwb),
        .addr        (addr),
        .irqb        (irqb16),
        .irqb_master (master16)
    );

    irq_controller_multi #(.NUM_IRQ(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .i_data      (i_data),
        .o_data      (o_data8),
        .cs          (cs),
        .rwb         (rwb),
        .addr        (addr),
        .irqb        (irqb8),
        .irqb_master (master8)
    );

    always #50 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        addr   = a;
        i_data = d;
        rwb    = 1'b0;
        cs     = 1'b1;
        @(posedge clk);
        #1;
        cs  = 1'b0;
        rwb = 1'b1;
    endtask

    task automatic check_reg16(input string tag, input logic [3:0] a, input logic [7:0] exp);
        addr = a;
        rwb  = 1'b1;
        cs   = 1'b1;
        #1;
        check_val(tag, o_data16, exp);
        cs = 1'b0;
    endtask

    task automatic check_reg8(input string tag, input logic [3:0] a, input logic [7:0] exp);
        addr = a;
        rwb  = 1'b1;
        cs   = 1'b1;
        #1;
        check_val(tag, o_data8, exp);
        cs = 1'b0;
    endtask

    task automatic check_m16(input string tag, input logic exp);
        check_val(tag, {7'b0000000, master16}, {7'b0000000, exp});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        cs     = 1'b0;
        rwb    = 1'b1;
        addr   = 4'h0;
        i_data = 8'h00;
        irqb16 = '0;
        irqb8  = '0;
        tick();
        tick();

        // reset state with every request asserted
        check_m16("rst_master16", 1'b1);
        check_val("rst_master8", {7'b0, master8}, 8'h01);
        check_reg16("rst_en0", 4'h0, 8'h00);
        check_reg16("rst_en1", 4'h1, 8'h00);
        check_reg16("rst_mode0", 4'h4, 8'h00);
        check_reg16("rst_ctrl", 4'hD, 8'h00);
        check_reg16("rst_pend0", 4'h8, 8'h00);
        check_reg16("rst_pend1", 4'h9, 8'h00);
        check_reg16("rst_vector", 4'hC, 8'h00);
        irqb16 = '1;
        irqb8  = '1;
        reset  = 1'b0;
        tick();
        tick();

        // level line 10: two-edge assertion and deassertion latency
        bus_write(4'h1, 8'h04);
        bus_write(4'hD, 8'h01);
        irqb16[10] = 1'b0;
        tick();
        check_m16("lvl_assert_e0", 1'b1);
        tick();
        check_m16("lvl_assert_e1", 1'b0);
        check_reg16("lvl_pend1", 4'h9, 8'h04);
        check_reg16("lvl_pend0", 4'h8, 8'h00);
        check_reg16("lvl_vector", 4'hC, 8'h8A);
        irqb16[10] = 1'b1;
        tick();
        check_m16("lvl_release_e0", 1'b0);
        tick();
        check_m16("lvl_release_e1", 1'b1);
        check_reg16("lvl_vector_idle", 4'hC, 8'h00);

        // level priority: line 9 pending but disabled, so 5 wins, then 3
        bus_write(4'h0, 8'h28);
        irqb16[5] = 1'b0;
        irqb16[9] = 1'b0;
        tick();
        tick();
        check_reg16("pri_vector5", 4'hC, 8'h85);
        check_reg16("pri_pend0", 4'h8, 8'h20);
        check_reg16("pri_pend1", 4'h9, 8'h02);
        check_m16("pri_master", 1'b0);
        irqb16[3] = 1'b0;
        tick();
        check_reg16("pri_vector3", 4'hC, 8'h83);
        check_reg16("pri_pend0_b", 4'h8, 8'h28);

        // global enable off keeps master high; VECTOR ignores it
        bus_write(4'hD, 8'h00);
        check_m16("gen_off_ew", 1'b0);
        tick();
        check_m16("gen_off_ew1", 1'b1);
        check_reg16("gen_off_vector", 4'hC, 8'h83);
        bus_write(4'hD, 8'h01);
        check_m16("gen_on_ew", 1'b1);
        tick();
        check_m16("gen_on_ew1", 1'b0);

        // W1C and ACK do nothing to level lines
        bus_write(4'h8, 8'h08);
        bus_write(4'hE, 8'h03);
        check_reg16("lvl_w1c_pend0", 4'h8, 8'h28);
        check_reg16("lvl_ack_vector", 4'hC, 8'h83);
        check_m16("lvl_ack_master", 1'b0);

        // clearing ENABLE masks the lines but leaves them pending
        bus_write(4'h0, 8'h00);
        tick();
        check_m16("mask_en_master", 1'b1);
        check_reg16("mask_en_vector", 4'hC, 8'h00);
        check_reg16("mask_en_pend0", 4'h8, 8'h28);
        irqb16 = '1;
        tick();
        tick();

`ifdef IRQ_EDGE_EN
        // edge mode: three-edge latency, latched pulses, priority
        bus_write(4'h1, 8'h00);
        bus_write(4'h4, 8'hFF);
        bus_write(4'h0, 8'hFF);
        check_reg16("edge_mode0", 4'h4, 8'hFF);
        check_reg16("edge_mode1", 4'h5, 8'h00);
        irqb16[5] = 1'b0;
        tick();
        check_m16("edge_e0", 1'b1);
        irqb16[5] = 1'b1;
        irqb16[2] = 1'b0;
        tick();
        check_m16("edge_e1", 1'b1);
        irqb16[2] = 1'b1;
        tick();
        check_m16("edge_e2", 1'b0);
        tick();
        check_reg16("edge_pend0", 4'h8, 8'h24);
        check_reg16("edge_vector", 4'hC, 8'h82);
        bus_write(4'hE, 8'h02);
        check_reg16("ack_vector", 4'hC, 8'h85);
        check_reg16("ack_pend0", 4'h8, 8'h20);
        bus_write(4'h8, 8'h20);
        check_reg16("w1c_vector", 4'hC, 8'h00);
        check_reg16("w1c_pend0", 4'h8, 8'h00);
        check_m16("w1c_master_ew", 1'b0);
        tick();
        check_m16("w1c_master_ew1", 1'b1);

        // ACK lands in the detecting cycle: the set wins; a held line cannot re-set
        irqb16[3] = 1'b0;
        tick();
        bus_write(4'hE, 8'h03);
        check_reg16("collide_pend0", 4'h8, 8'h08);
        bus_write(4'hE, 8'h03);
        check_reg16("held_ack_pend0", 4'h8, 8'h00);
        tick();
        tick();
        check_reg16("held_no_retrig", 4'h8, 8'h00);
        irqb16[3] = 1'b1;
        tick();
        tick();

        // edge latched on disabled line 7
        bus_write(4'h0, 8'h7F);
        irqb16[7] = 1'b0;
        tick();
        irqb16[7] = 1'b1;
        tick();
        tick();
        tick();
        check_m16("dis7_master", 1'b1);
        check_reg16("dis7_pend0", 4'h8, 8'h80);
        check_reg16("dis7_vector", 4'hC, 8'h00);
        bus_write(4'h0, 8'h80);
        check_m16("en7_master_ew", 1'b1);
        tick();
        check_m16("en7_master_ew1", 1'b0);
        check_reg16("en7_vector", 4'hC, 8'h87);
        bus_write(4'hD, 8'h00);
        tick();
        check_m16("en7_gen_off", 1'b1);

        // edge->level keeps the latch hidden and immune to clears
        bus_write(4'h4, 8'h7F);
        check_reg16("lvl7_pend0", 4'h8, 8'h00);
        bus_write(4'h8, 8'h80);
        bus_write(4'hE, 8'h07);
        bus_write(4'h4, 8'hFF);
        check_reg16("back_edge7_pend0", 4'h8, 8'h80);
        bus_write(4'h8, 8'h80);
        check_reg16("clr7_pend0", 4'h8, 8'h00);
        bus_write(4'h4, 8'h00);
        bus_write(4'hD, 8'h01);
`else
        // level-only build: MODE is inert and a short pulse is not latched
        bus_write(4'h4, 8'hFF);
        check_reg16("nomode_mode0", 4'h4, 8'h00);
        bus_write(4'h0, 8'h10);
        irqb16[4] = 1'b0;
        tick();
        irqb16[4] = 1'b1;
        tick();
        check_reg16("nolatch_pend0", 4'h8, 8'h00);
        check_m16("nolatch_master_e1", 1'b0);
        tick();
        check_m16("nolatch_master_e2", 1'b1);
`endif
        bus_write(4'h0, 8'h00);

        // asynchronous reset in the middle of an active interrupt
        bus_write(4'h0, 8'h01);
        bus_write(4'hD, 8'h01);
        irqb16[0] = 1'b0;
        tick();
        tick();
        check_m16("pre_areset_master", 1'b0);
        #20;
        reset = 1'b1;
        #1;
        check_m16("areset_master", 1'b1);
        check_reg16("areset_en0", 4'h0, 8'h00);
        check_reg16("areset_ctrl", 4'hD, 8'h00);
        check_reg16("areset_pend0", 4'h8, 8'h00);
        irqb16 = '1;
        #10;
        reset = 1'b0;
        tick();

        // bounds on the 8-line instance
        bus_write(4'h0, 8'h5A);
        bus_write(4'h1, 8'hFF);
        bus_write(4'h2, 8'hFF);
        bus_write(4'h3, 8'hFF);
        bus_write(4'h5, 8'hFF);
        bus_write(4'h9, 8'hFF);
        bus_write(4'hE, 8'h1F);
        bus_write(4'hD, 8'h01);
        bus_write(4'h4, 8'hFF);
        check_reg8("b8_en0", 4'h0, 8'h5A);
        check_reg8("b8_en1", 4'h1, 8'h00);
        check_reg8("b8_en2", 4'h2, 8'h00);
        check_reg8("b8_en3", 4'h3, 8'h00);
        check_reg8("b8_mode1", 4'h5, 8'h00);
        check_reg8("b8_mode0", 4'h4, MODE_EXP);
        check_reg8("b8_ctrl", 4'hD, 8'h01);
        check_reg8("b8_pend0", 4'h8, 8'h00);
        check_reg8("b8_vector", 4'hC, 8'h00);
        check_val("b8_master_idle", {7'b0, master8}, 8'h01);
        check_reg16("b16_en1", 4'h1, 8'hFF);
        check_reg16("b16_en2", 4'h2, 8'h00);
        check_reg16("b16_en3", 4'h3, 8'h00);
        irqb8[1] = 1'b0;
        tick();
        tick();
        tick();
        check_val("b8_master_irq1", {7'b0, master8}, 8'h00);
        check_reg8("b8_vector_irq1", 4'hC, 8'h81);
        check_reg8("b8_pend0_irq1", 4'h8, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
